// File: rtl/bus_pkg.sv
// Shared bus definitions: receiver state encoding and instruction codes.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RECV  = 2'd2,
    PAR   = 2'd3
  } state_e;

  localparam logic [1:0] INSTR_READ = 2'b11;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as zero while empty.
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push_s, do_pop_s;

  assign empty     = (count_q == {CW{1'b0}});
  assign full      = (count_q == CW'(DEPTH));
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign head      = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are never observed while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/master_rx_burst.sv
// Serial read-burst receiver: LSB-first deserialiser feeding an FWFT FIFO.
// Optional per-word even parity is enabled by defining MASTER_RX_PARITY_EN.
module master_rx_burst
  import bus_pkg::*;
#(
  parameter int DATA_LEN   = 8,
  parameter int BURST_LEN  = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           instruction,
  input  logic                 approval_grant,
  input  logic [BURST_LEN-1:0] burst_num,
  input  logic                 slave_valid,
  input  logic                 rx_data,
  output logic                 master_ready,
  output logic [DATA_LEN-1:0]  data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 rx_done,
  output logic                 rx_abort,
  output logic                 rx_err,
  output logic                 busy
);
  localparam int BW = $clog2(DATA_LEN);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_LEN - 1);

  state_e               state_q, state_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_LEN-1:0]  shift_q, shift_d;
  logic [BURST_LEN-1:0] word_cnt_q, word_cnt_d;
  logic [BURST_LEN-1:0] burst_q, burst_d;
  logic                 done_q, done_d, abort_q, abort_d, err_q, err_d;
  logic                 push_s, word_end_s, accept_s, fifo_full_s, fifo_empty_s;
  logic [DATA_LEN-1:0]  push_data_s;

`ifdef MASTER_RX_PARITY_EN
  function automatic logic even_par(input logic [DATA_LEN-1:0] w);
    return ^w;
  endfunction
`endif

  assign master_ready = ((state_q == RECV) || (state_q == PAR)) && !fifo_full_s && approval_grant;
  assign accept_s     = slave_valid && master_ready;
  assign busy         = (state_q != IDLE);
  assign data_valid   = !fifo_empty_s;
  assign rx_done      = done_q;
  assign rx_abort     = abort_q;
  assign rx_err       = err_q;

  // Next-state, datapath updates and pulse generation.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    word_cnt_d  = word_cnt_q;
    burst_d     = burst_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    err_d       = 1'b0;
    push_s      = 1'b0;
    push_data_s = shift_q;
    word_end_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (instruction == INSTR_READ) begin
          state_d    = GRANT;
          burst_d    = burst_num;
          bit_cnt_d  = {BW{1'b0}};
          word_cnt_d = {BURST_LEN{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (approval_grant) state_d = RECV;
        else                state_d = GRANT;
      end
      RECV: begin
        if (!approval_grant) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (accept_s) begin
          shift_d[bit_cnt_q] = rx_data;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = {BW{1'b0}};
`ifdef MASTER_RX_PARITY_EN
            state_d = PAR;
`else
            push_s      = 1'b1;
            push_data_s = shift_d;
            word_end_s  = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          state_d = RECV;
        end
      end
`ifdef MASTER_RX_PARITY_EN
      PAR: begin
        if (!approval_grant) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (accept_s) begin
          if (rx_data == even_par(shift_q)) push_s = 1'b1;
          else                              err_d  = 1'b1;
          word_end_s = 1'b1;
          state_d    = RECV;
        end else begin
          state_d = PAR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // A word (pushed or dropped) always counts toward the burst.
    if (word_end_s) begin
      if (word_cnt_q == burst_q) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        word_cnt_d = word_cnt_q + 1'b1;
      end
    end else begin
      word_cnt_d = word_cnt_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= {BW{1'b0}};
      shift_q    <= {DATA_LEN{1'b0}};
      word_cnt_q <= {BURST_LEN{1'b0}};
      burst_q    <= {BURST_LEN{1'b0}};
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      word_cnt_q <= word_cnt_d;
      burst_q    <= burst_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      err_q      <= err_d;
    end
  end

  rx_fifo #(
    .WIDTH(DATA_LEN),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_s),
    .push_data(push_data_s),
    .pop      (data_ready),
    .head     (data),
    .empty    (fifo_empty_s),
    .full     (fifo_full_s)
  );

endmodule
